// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared widths, LFSR/MISR constants and FSM states for the BIST chip
package bist_pkg;

  localparam int PI_W = 35;
  localparam int PO_W = 49;

  localparam int LFSR_TAP_A = 34;
  localparam int LFSR_TAP_B = 32;

  // x^49 + x^9 + 1 with the x^49 term implied by the shift-out bit
  localparam logic [PO_W-1:0] MISR_POLY = 49'h201;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [PI_W-1:0] lfsr_next(input logic [PI_W-1:0] s);
    return {s[PI_W-2:0], s[LFSR_TAP_A] ^ s[LFSR_TAP_B]};
  endfunction

endpackage

// File: rtl/bist_chip_if.sv
// rtl/bist_chip_if.sv - chip-level pins: primary I/O plus BIST control and status
interface bist_chip_if;
  import bist_pkg::*;

  logic [PI_W-1:0] pi;
  logic [PO_W-1:0] po;
  logic            bistmode;
  logic            bistdone;
  logic            bistpass;

  modport master (output pi, output bistmode, input po, input bistdone, input bistpass);
  modport slave  (input pi, input bistmode, output po, output bistdone, output bistpass);

endinterface

// File: rtl/bist_ctrl.sv
// rtl/bist_ctrl.sv - BIST sequencer: pattern LFSR, response MISR, counter and signature check
module bist_ctrl
  import bist_pkg::*;
#(
  parameter int              N_PATTERNS = 2000,
  parameter logic [PI_W-1:0] LFSR_SEED  = 35'h1,
  parameter logic [PO_W-1:0] GOLDEN_SIG = 49'h0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bistmode,
  input  logic [PO_W-1:0] cut_po,
  output logic [PI_W-1:0] lfsr_out,
  output logic            run,
  output logic            bistdone,
  output logic            bistpass
);

  localparam int CNT_W = (N_PATTERNS > 1) ? $clog2(N_PATTERNS) : 1;

  state_t          state_q, state_d;
  logic [PI_W-1:0] lfsr_q, lfsr_d;
  logic [PO_W-1:0] misr_q, misr_d, misr_next;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;

  assign misr_next = {misr_q[PO_W-2:0], 1'b0} ^ (misr_q[PO_W-1] ? MISR_POLY : '0) ^ cut_po;

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    misr_d  = misr_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE: begin
        if (bistmode) state_d = RUN;
      end
      RUN: begin
        if (!bistmode) begin
          // aborted run restarts from scratch on the next request
          state_d = IDLE;
          lfsr_d  = LFSR_SEED;
          misr_d  = '0;
          cnt_d   = '0;
        end else begin
          lfsr_d = lfsr_next(lfsr_q);
          misr_d = misr_next;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(N_PATTERNS - 1)) begin
            state_d = DONE;
            done_d  = 1'b1;
            pass_d  = (misr_next == GOLDEN_SIG);
          end
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lfsr_q  <= LFSR_SEED;
      misr_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      misr_q  <= misr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign lfsr_out = lfsr_q;
  assign run      = (state_q == RUN);
  assign bistdone = done_q;
  assign bistpass = pass_q;

endmodule

// File: rtl/bist_cut.sv
// rtl/bist_cut.sv - circuit under test: 35-in/49-out logic with a 14-bit state register
module bist_cut
  import bist_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [PI_W-1:0] pi,
  output logic [PO_W-1:0] po
);

  logic [13:0]     r_q, r_d;
  logic [PI_W-1:0] mix_w;
  logic            par_w;

  assign mix_w = {pi[PI_W-2:0], pi[PI_W-1]} & {pi[PI_W-3:0], pi[PI_W-1:PI_W-2]};
  assign par_w = ^pi;
  assign po    = {r_q, pi ^ mix_w};

  always_comb begin
    r_d = {r_q[12:0], r_q[13] ^ par_w} ^ pi[13:0] ^ pi[34:21];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else begin
      r_q <= r_d;
    end
  end

endmodule

// File: rtl/bist_chip.sv
// rtl/bist_chip.sv - chip top: CUT input mux, BIST sequencer and the CUT instance
module bist_chip
  import bist_pkg::*;
#(
  parameter int              N_PATTERNS = 2000,
  parameter logic [PI_W-1:0] LFSR_SEED  = 35'h1,
  parameter logic [PO_W-1:0] GOLDEN_SIG = 49'h0
) (
  input logic        clk,
  input logic        rst,
  bist_chip_if.slave bus
);

  logic            run;
  logic [PI_W-1:0] lfsr_out;
  logic [PI_W-1:0] cut_pi;
  logic [PO_W-1:0] cut_po;

  assign cut_pi = run ? lfsr_out : bus.pi;
  assign bus.po = cut_po;

  bist_ctrl #(
    .N_PATTERNS (N_PATTERNS),
    .LFSR_SEED  (LFSR_SEED),
    .GOLDEN_SIG (GOLDEN_SIG)
  ) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .bistmode (bus.bistmode),
    .cut_po   (cut_po),
    .lfsr_out (lfsr_out),
    .run      (run),
    .bistdone (bus.bistdone),
    .bistpass (bus.bistpass)
  );

  bist_cut circuit (
    .clk (clk),
    .rst (rst),
    .pi  (cut_pi),
    .po  (cut_po)
  );

endmodule

// File: tb/tb_bist_chip.sv
// tb/tb_bist_chip.sv - randomized self-checking bench for bist_chip against a behavioural model
module tb_bist_chip;

  localparam int          NP     = 128;
  localparam logic [34:0] SEED   = 35'h4_2B1C_0D37;
  localparam logic [49:0] POLY50 = 50'h2_0000_0000_0201;

  function automatic logic [34:0] rotl35(input logic [34:0] x, input int n);
    return (x << n) | (x >> (35 - n));
  endfunction

  function automatic logic [13:0] rotl14(input logic [13:0] x);
    return (x << 1) | (x >> 13);
  endfunction

  function automatic logic [48:0] cut_po_f(input logic [34:0] p, input logic [13:0] r);
    return {r, p ^ (rotl35(p, 1) & rotl35(p, 2))};
  endfunction

  function automatic logic [13:0] cut_r_f(input logic [34:0] p, input logic [13:0] r, input logic stuck);
    logic par;
    par = stuck ? 1'b1 : ^p;
    return rotl14(r) ^ {13'b0, par} ^ p[13:0] ^ p[34:21];
  endfunction

  function automatic logic [48:0] misr_f(input logic [48:0] m, input logic [48:0] d);
    logic [49:0] t;
    t = {m, 1'b0};
    if (t[49]) t = t ^ POLY50;
    return t[48:0] ^ d;
  endfunction

  function automatic logic [34:0] lfsr_f(input logic [34:0] s);
    return {s[33:0], s[34] ^ s[32]};
  endfunction

  function automatic logic [48:0] model_sig(input logic [34:0] entry_pi, input logic stuck);
    logic [13:0] r;
    logic [34:0] l;
    logic [48:0] m;
    r = cut_r_f(entry_pi, 14'h0, stuck);
    l = SEED;
    m = '0;
    for (int k = 0; k < NP; k++) begin
      m = misr_f(m, cut_po_f(l, r));
      r = cut_r_f(l, r, stuck);
      l = lfsr_f(l);
    end
    return m;
  endfunction

  localparam logic [48:0] GOLD   = model_sig(35'h0, 1'b0);
  localparam logic [48:0] GOLD_B = GOLD ^ 49'h1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [13:0] r_m;

  bist_chip_if bus_a ();
  bist_chip_if bus_b ();

  bist_chip #(.N_PATTERNS(NP), .LFSR_SEED(SEED), .GOLDEN_SIG(GOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  bist_chip #(.N_PATTERNS(NP), .LFSR_SEED(SEED), .GOLDEN_SIG(GOLD_B)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [34:0] rand35();
    return 35'({$urandom(), $urandom()});
  endfunction

  task automatic drive(input logic [34:0] p, input logic m);
    bus_a.pi = p;
    bus_b.pi = p;
    bus_a.bistmode = m;
    bus_b.bistmode = m;
  endtask

  task automatic run_bist(input logic stuck, input string tag);
    logic [48:0] sig;
    logic        exp_a, exp_b;
    int          edge_a, edge_b;
    sig   = model_sig(35'h0, stuck);
    exp_a = (sig == GOLD);
    exp_b = (sig == GOLD_B);
    drive(35'h0, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    edge_a = 0;
    edge_b = 0;
    for (int e = 1; e <= NP + 20 && (edge_a == 0 || edge_b == 0); e++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus_a.bistdone && edge_a == 0) edge_a = e;
      if (bus_b.bistdone && edge_b == 0) edge_b = e;
      drive(rand35(), 1'b1);
    end
    check_val({tag, "_done_edge_a"}, 64'(edge_a), 64'(NP + 1));
    check_val({tag, "_done_edge_b"}, 64'(edge_b), 64'(NP + 1));
    check_val({tag, "_pass_a"}, 64'(bus_a.bistpass), 64'(exp_a));
    check_val({tag, "_pass_b"}, 64'(bus_b.bistpass), 64'(exp_b));
    for (int i = 0; i < 50; i++) begin
      drive(rand35(), 1'($urandom_range(0, 1)));
      @(posedge clk);
      @(negedge clk);
      check_val({tag, "_hold"},
                64'({bus_a.bistdone, bus_a.bistpass, bus_b.bistdone, bus_b.bistpass}),
                64'({1'b1, exp_a, 1'b1, exp_b}));
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val({tag, "_rst_clear"},
              64'({bus_a.bistdone, bus_a.bistpass, bus_b.bistdone, bus_b.bistpass}), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [34:0] p;
    drive(35'h0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("reset_status",
              64'({bus_a.bistdone, bus_a.bistpass, bus_b.bistdone, bus_b.bistpass}), 64'(0));
    check_val("reset_po", 64'(bus_a.po), 64'(cut_po_f(35'h0, 14'h0)));
    rst = 1'b0;
    r_m = '0;

    // system mode: chip pi straight into the CUT
    for (int i = 0; i < 24; i++) begin
      p = (i == 0) ? 35'h5_5555_5555 : rand35();
      drive(p, 1'b0);
      #1;
      check_val("sys_po", 64'(bus_a.po), 64'(cut_po_f(p, r_m)));
      check_val("sys_cut_pi", 64'(dut.circuit.pi), 64'(p));
      check_val("sys_status",
                64'({bus_a.bistdone, bus_a.bistpass, bus_b.bistdone, bus_b.bistpass}), 64'(0));
      @(posedge clk);
      r_m = cut_r_f(p, r_m, 1'b0);
      @(negedge clk);
    end

    run_bist(1'b0, "good");

    force dut.circuit.par_w = 1'b1;
    force dut_b.circuit.par_w = 1'b1;
    run_bist(1'b1, "stuck");
    release dut.circuit.par_w;
    release dut_b.circuit.par_w;

    // abort a run part-way through, then run again cleanly
    drive(35'h0, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 100; i++) begin
      drive(rand35(), 1'b1);
      @(posedge clk);
      @(negedge clk);
    end
    check_val("abort_running", 64'({dut.run, bus_a.bistdone}), 64'({1'b1, 1'b0}));
    drive(rand35(), 1'b0);
    @(posedge clk);
    @(negedge clk);
    check_val("abort_idle", 64'(dut.run), 64'(0));
    check_val("abort_misr", 64'(dut.u_ctrl.misr_q), 64'(0));
    check_val("abort_lfsr", 64'(dut.u_ctrl.lfsr_q), 64'(SEED));
    for (int i = 0; i < 10; i++) begin
      drive(rand35(), 1'b0);
      @(posedge clk);
      @(negedge clk);
    end
    check_val("abort_done", 64'({bus_a.bistdone, bus_b.bistdone}), 64'(0));

    run_bist(1'b0, "rerun");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bist_chip.md
Name: bist_chip

Overview:
Top-level chip wrapping a 35-input / 49-output sequential combinational-logic core (CUT) with built-in self-test.
- System mode (bistmode=0): primary inputs go straight to the CUT, and CUT outputs drive po.
- BIST mode (bistmode=1): an on-chip LFSR drives the CUT inputs and a MISR compacts the CUT outputs. After a fixed pattern count, the MISR is compared against a golden signature and bistdone/bistpass are reported.

Parameters:
- N_PATTERNS, 2000: number of BIST pattern cycles applied to the CUT.
- LFSR_SEED, 35'h1: LFSR reset value; must be nonzero.
- GOLDEN_SIG, 49'h0: expected MISR signature. Set it from a fault-free simulation of the same N_PATTERNS and LFSR_SEED.

Ports:
- clk, input, 1: single system clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- pi, input, 35: primary inputs; bit 34 is the MSB.
- po, output, 49: primary outputs, always equal to the CUT outputs.
- bistmode, input, 1: 1 = BIST mode, 0 = system mode.
- bistdone, output, 1: BIST run complete.
- bistpass, output, 1: signature matched; valid only when bistdone=1.

Behaviour:

CUT instance
- Instance name is "circuit"; hierarchical probes depend on this name.
- CUT ports: clk, rst, pi[34:0], po[48:0].
- CUT rst is driven by chip rst.
- CUT pi input:
  - equals the LFSR state while the FSM is in RUN;
  - equals chip pi otherwise.

Reset (rst=1 at a clk edge)
- FSM goes to IDLE.
- LFSR is loaded with LFSR_SEED.
- MISR, pattern counter, bistdone and bistpass are all cleared to 0.

FSM states: IDLE, RUN, DONE
- IDLE:
  - if bistmode=1, go to RUN;
  - otherwise stay in IDLE.
  - bistdone=0.
- RUN, on each clock:
  - LFSR advances: next = {lfsr[33:0], lfsr[34]^lfsr[32]} (x^35+x^33+1).
  - MISR captures: next = ({misr[47:0],1'b0} ^ (misr[48] ? 49'h200 | 49'h1 : 0)) ^ cut_po, i.e. polynomial x^49+x^9+1.
  - Counter increments.
  - On the cycle with counter == N_PATTERNS-1, go to DONE and register:
    - bistdone <= 1;
    - bistpass <= (misr_next == GOLDEN_SIG).
- DONE:
  - Hold bistdone, bistpass, misr and lfsr until rst.
  - Ignore bistmode.
- bistmode dropping to 0 while in RUN: return to IDLE, clear the counter and MISR, reload the LFSR seed. bistdone stays 0.

Latency
- The first rising edge with rst=0 and bistmode=1 enters RUN.
- bistdone rises N_PATTERNS edges later, and is visible after edge N_PATTERNS+1.

Other requirements
- bistdone and bistpass are registered and glitch-free.
- po is never gated.
- System mode never touches the LFSR or MISR beyond holding their reset values.

Decomposition:
- Package bist_pkg:
  - PI_W=35 and PO_W=49;
  - LFSR tap positions (34, 32);
  - MISR polynomial constant 49'h201;
  - FSM state enum {IDLE, RUN, DONE}.
- Sub-module bist_ctrl: FSM, counter, LFSR, MISR and comparator.
  - Inputs: clk, rst, bistmode, cut_po.
  - Outputs: lfsr_out, run, bistdone, bistpass.
- bist_chip contains only the pi mux, the bist_ctrl instance and the CUT instance "circuit".

Test Plan:
- Reset, then bistmode=0, apply pi=35'h5_5555_5555 → pi reaches circuit unchanged and po tracks the CUT reference model. bistdone=0 and bistpass=0 throughout.
- Pulse rst for one cycle with bistmode=1, GOLDEN_SIG taken from the fault-free model → bistdone rises exactly N_PATTERNS+1 edges after rst falls, with bistpass=1.
- Same run but force one CUT internal net stuck-at-1 → bistdone at the same cycle, bistpass=0.
- Same run with GOLDEN_SIG off by one bit, no fault → bistpass=0.
- Drop bistmode after 100 RUN cycles → FSM returns to IDLE, bistdone stays 0, the MISR is cleared, and a fresh rst plus bistmode run completes normally.
- After DONE, hold 50 extra cycles toggling bistmode and pi → bistdone and bistpass stay stable. A new rst clears both to 0.
